// File: rtl/reset_sequencer.sv
// Board reset controller: releases downstream reset domains in index order once the
// PLL lock is stable and the button is released; re-asserts them on lock loss or press.
module reset_sequencer #(
    parameter int STAGES          = 2,
    parameter int LOCK_CYCLES     = 1024,
    parameter int STAGE_CYCLES    = 256,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_pllLock,
    input  logic              io_buttonN,
    output logic [STAGES-1:0] io_resetOut,
    output logic              io_ready,
    output logic [1:0]        io_cause,
    output logic [7:0]        io_faultCount
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int TW = $clog2(STAGE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int KW = $clog2(STAGES + 1);

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(STAGES - 1);

    typedef enum logic [1:0] {
        HOLD,
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic              lockMeta_q, lockSync_q;
    logic              btnMeta_q, btnSync_q;
    logic              btnDeb_q, btnDeb_d;
    logic [DW-1:0]     dbCnt_q, dbCnt_d;
    logic [LW-1:0]     lockCnt_q, lockCnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [KW-1:0]     stage_q, stage_d;
    logic [STAGES-1:0] resetOut_q, resetOut_d;
    logic              ready_q, ready_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        faultCount_q, faultCount_d;

    logic pressed;
    logic fault;
    logic stageDone;

    assign pressed   = ~btnDeb_q;
    assign fault     = ((state_q == RELEASE) || (state_q == RUN)) && (~lockSync_q || pressed);
    assign stageDone = (timer_q == STAGE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HOLD;
            lockMeta_q   <= 1'b0;
            lockSync_q   <= 1'b0;
            btnMeta_q    <= 1'b0;
            btnSync_q    <= 1'b0;
            btnDeb_q     <= 1'b1;
            dbCnt_q      <= '0;
            lockCnt_q    <= '0;
            timer_q      <= '0;
            stage_q      <= '0;
            resetOut_q   <= '1;
            ready_q      <= 1'b0;
            cause_q      <= 2'd0;
            faultCount_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            lockMeta_q   <= io_pllLock;
            lockSync_q   <= lockMeta_q;
            btnMeta_q    <= io_buttonN;
            btnSync_q    <= btnMeta_q;
            btnDeb_q     <= btnDeb_d;
            dbCnt_q      <= dbCnt_d;
            lockCnt_q    <= lockCnt_d;
            timer_q      <= timer_d;
            stage_q      <= stage_d;
            resetOut_q   <= resetOut_d;
            ready_q      <= ready_d;
            cause_q      <= cause_d;
            faultCount_q <= faultCount_d;
        end
    end

    // The debounced level only follows btnSync after it has disagreed for a full window.
    always_comb begin
        btnDeb_d = btnDeb_q;
        dbCnt_d  = '0;
        if (btnSync_q != btnDeb_q) begin
            if (dbCnt_q == DB_LAST) begin
                btnDeb_d = btnSync_q;
            end else begin
                dbCnt_d = dbCnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lockCnt_d = '0;
        timer_d   = '0;
        stage_d   = '0;
        unique case (state_q)
            HOLD: begin
                if (!pressed) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (pressed) begin
                    state_d = HOLD;
                end else if (lockSync_q) begin
                    if (lockCnt_q == LOCK_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        lockCnt_d = lockCnt_q + 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (fault) begin
                    state_d = HOLD;
                end else if (stageDone) begin
                    stage_d = stage_q + 1'b1;
                    if (stage_q == K_LAST) begin
                        state_d = RUN;
                    end
                end else begin
                    stage_d = stage_q;
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (fault) begin
                    state_d = HOLD;
                end else begin
                    stage_d = stage_q;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // A fault wins over a stage release on the same edge because it forces state_d to HOLD.
    always_comb begin
        resetOut_d   = resetOut_q;
        cause_d      = cause_q;
        faultCount_d = faultCount_q;
        ready_d      = (state_d == RUN);
        if ((state_d == HOLD) || (state_d == WAIT_LOCK)) begin
            resetOut_d = '1;
        end else if ((state_q == RELEASE) && stageDone) begin
            for (int i = 0; i < STAGES; i++) begin
                if (stage_q == KW'(i)) begin
                    resetOut_d[i] = 1'b0;
                end
            end
        end
        if (fault) begin
            cause_d = {pressed, ~lockSync_q};
            if (faultCount_q != 8'hFF) begin
                faultCount_d = faultCount_q + 8'd1;
            end
        end
    end

    assign io_resetOut   = resetOut_q;
    assign io_ready      = ready_q;
    assign io_cause      = cause_q;
    assign io_faultCount = faultCount_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: a timeline-level reference model pushes the
// expected outputs per edge into a scoreboard queue that a negedge monitor drains.
module tb_reset_sequencer;

    localparam int STAGES          = 2;
    localparam int LOCK_CYCLES     = 4;
    localparam int STAGE_CYCLES    = 3;
    localparam int DEBOUNCE_CYCLES = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_pllLock;
    logic              io_buttonN;
    logic [STAGES-1:0] io_resetOut;
    logic              io_ready;
    logic [1:0]        io_cause;
    logic [7:0]        io_faultCount;

    reset_sequencer #(
        .STAGES         (STAGES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .STAGE_CYCLES   (STAGE_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_pllLock   (io_pllLock),
        .io_buttonN   (io_buttonN),
        .io_resetOut  (io_resetOut),
        .io_ready     (io_ready),
        .io_cause     (io_cause),
        .io_faultCount(io_faultCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [STAGES-1:0] rst;
        logic              ready;
        logic [1:0]        cause;
        logic [7:0]        count;
    } exp_t;

    typedef enum {M_HOLD, M_WAIT, M_SEQ} mode_t;

    exp_t  expQ[$];
    int    checkCount = 0;
    int    passCount  = 0;
    int    cycle      = 0;

    bit    lockHist[$];
    bit    btnHist[$];
    bit    btnWin[$];
    mode_t mMode;
    int    mLockRun;
    int    mElapsed;
    bit    mDeb;
    int    mCause;
    int    mCount;

    // Reference: synchronized pins are the samples from two edges back; release progress
    // is elapsed edges in the sequence divided by the stage spacing.
    always @(posedge clock) begin : model
        bit   lockS, btnS, pressed, allDiffer;
        int   r, mask;
        exp_t e;
        cycle++;
        if (reset) begin
            lockHist.delete(); lockHist.push_back(1'b0); lockHist.push_back(1'b0);
            btnHist.delete();  btnHist.push_back(1'b0);  btnHist.push_back(1'b0);
            btnWin.delete();
            mMode = M_HOLD; mLockRun = 0; mElapsed = 0;
            mDeb = 1'b1; mCause = 0; mCount = 0;
        end else begin
            lockS   = lockHist[lockHist.size()-2];
            btnS    = btnHist[btnHist.size()-2];
            pressed = !mDeb;
            case (mMode)
                M_HOLD: begin
                    if (!pressed) begin mMode = M_WAIT; mLockRun = 0; end
                end
                M_WAIT: begin
                    if (pressed) mMode = M_HOLD;
                    else if (lockS) begin
                        mLockRun++;
                        if (mLockRun == LOCK_CYCLES) begin mMode = M_SEQ; mElapsed = 0; end
                    end else mLockRun = 0;
                end
                default: begin
                    if (!lockS || pressed) begin
                        mMode  = M_HOLD;
                        mCause = (lockS ? 0 : 1) + (pressed ? 2 : 0);
                        if (mCount < 255) mCount++;
                    end else mElapsed++;
                end
            endcase
            btnWin.push_back(btnS);
            if (btnWin.size() > DEBOUNCE_CYCLES) void'(btnWin.pop_front());
            allDiffer = (btnWin.size() == DEBOUNCE_CYCLES);
            foreach (btnWin[i]) if (btnWin[i] == mDeb) allDiffer = 1'b0;
            if (allDiffer) begin mDeb = !mDeb; btnWin.delete(); end
            lockHist.push_back(io_pllLock);
            btnHist.push_back(io_buttonN);
            while (lockHist.size() > 3) void'(lockHist.pop_front());
            while (btnHist.size() > 3) void'(btnHist.pop_front());
        end
        if (mMode == M_SEQ) begin
            r = mElapsed / STAGE_CYCLES;
            if (r > STAGES) r = STAGES;
            mask = ((1 << STAGES) - 1) & ~((1 << r) - 1);
            e.rst   = mask[STAGES-1:0];
            e.ready = (r == STAGES);
        end else begin
            e.rst   = '1;
            e.ready = 1'b0;
        end
        e.cause = 2'(mCause);
        e.count = 8'(mCount);
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s cycle %0d: got %0d want %0d", name, cycle, actual, expected);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("resetOut",   8'(io_resetOut), 8'(e.rst));
            checkOutput("ready",      8'(io_ready),    8'(e.ready));
            checkOutput("cause",      8'(io_cause),    8'(e.cause));
            checkOutput("faultCount", io_faultCount,   e.count);
        end
    end

    task automatic applyStimulus(input bit lock, input bit btnN, input bit rst);
        @(negedge clock);
        io_pllLock = lock;
        io_buttonN = btnN;
        reset      = rst;
    endtask

    initial begin : stimulus
        int pressLeft;
        bit l, b, r;
        reset = 1'b1; io_pllLock = 1'b0; io_buttonN = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);

        // Power-up, then lock loss in RUN, then button pulses and a long press.
        for (int e = 0; e < 20; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int e = 0; e < 20; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 2; e++)  applyStimulus(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 10; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int e = 0; e < 8; e++)  applyStimulus(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 25; e++) applyStimulus(1'b1, 1'b1, 1'b0);

        // Lock flap while waiting for lock.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int e = 0; e < 25; e++) applyStimulus(e != 3, 1'b1, 1'b0);

        // Lock drop and debounced press land on the same edge while one domain is released.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int e = 0; e < 40; e++) applyStimulus(e != 8, !(e >= 4 && e <= 14), 1'b0);

        // Synchronous reset in the middle of the release.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int e = 0; e < 30; e++) applyStimulus(1'b1, 1'b1, e == 9);

        // Repeated lock-loss faults to drive the fault counter into saturation.
        for (int f = 0; f < 262; f++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            for (int e = 0; e < 12; e++) applyStimulus(1'b1, 1'b1, 1'b0);
        end

        pressLeft = 0;
        for (int c = 0; c < 3000; c++) begin
            l = ($urandom_range(0, 99) >= 3);
            if (pressLeft == 0 && $urandom_range(0, 99) < 3) pressLeft = $urandom_range(1, 10);
            b = (pressLeft == 0);
            if (pressLeft > 0) pressLeft--;
            r = ($urandom_range(0, 999) < 3);
            applyStimulus(l, b, r);
        end

        repeat (3) @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Board-level reset controller. Sequences release of several downstream reset domains (e.g. memory/peripherals, then Core) once the PLL lock is stable and the board button is released.
- Re-asserts all domain resets on PLL lock loss or a debounced button press, and records the cause.
- Replaces the single stretch counter in the top level. Runs on the PLL output clock.

Parameters:
- STAGES, 2, number of reset domains, released in index order 0..STAGES-1.
- LOCK_CYCLES, 1024, consecutive synchronized lock-high cycles required before release starts (>=1).
- STAGE_CYCLES, 256, cycles between consecutive stage releases (>=1).
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles needed to change the debounced button state (>=1).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- io_pllLock  in  1  PLL lock, asynchronous; 2-flop synchronized internally.
- io_buttonN  in  1  board reset button, active-low, asynchronous; 2-flop synchronized, then debounced.
- io_resetOut  out  STAGES  per-domain reset, active-high; bit k drives domain k.
- io_ready  out  1  high only in RUN (all domains released).
- io_cause  out  2  cause of last fault: 0 none, 1 lock loss, 2 button, 3 both in the same cycle.
- io_faultCount  out  8  number of faults, saturating at 255.

Behaviour:
- Reset values:
  - io_resetOut all ones, io_ready 0, io_cause 0, io_faultCount 0.
  - State HOLD; all counters 0.
  - Synchronizer flops 0; debounced button = released.
- All outputs are registered.
- Synchronizers: 2 flops each. lock_s / btn_s lag the pins by 2 edges.
- Debounce:
  - A counter runs while btn_s differs from the debounced state; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still differing, the debounced state flips on that edge.
  - pressed = (debounced level == 0).
- HOLD:
  - io_resetOut all ones.
  - Go to WAIT_LOCK on the next edge if not pressed; otherwise stay.
- WAIT_LOCK:
  - lockcnt increments on each edge with lock_s=1. It clears to 0 on any edge with lock_s=0; this is not a fault.
  - On an edge with lock_s=1 and lockcnt==LOCK_CYCLES-1, go to RELEASE with k=0, timer=0.
  - pressed in this state → HOLD; not a fault.
- RELEASE, each edge:
  - If timer==STAGE_CYCLES-1: clear io_resetOut[k], set timer=0, k=k+1.
  - Otherwise timer=timer+1.
  - On the edge that clears bit STAGES-1, go to RUN; io_ready=1 on that same edge.
  - Released bits stay 0. Bits are never released out of order.
- RUN: hold the state. io_ready=1.
- Fault (only evaluated in RELEASE or RUN), when lock_s==0 or pressed:
  - Next edge: state HOLD, io_resetOut all ones, io_ready 0.
  - io_cause updated (3 if both conditions are present); io_faultCount increments, saturating.
  - lockcnt, timer and k all clear.
  - Fault takes priority over a stage release on the same edge.
- io_cause is sticky until the next fault. Synchronous reset mid-operation returns every output to its reset value on that edge.
- Counter widths: clog2 of each parameter's max + 1. k is clog2(STAGES+1) bits. No wrap: counters are bounded by state transitions.

Test Plan:
(Use STAGES=2, LOCK_CYCLES=4, STAGE_CYCLES=3, DEBOUNCE_CYCLES=4. Edge 0 = first edge with reset=0.)
- Power-up: pllLock=1 and buttonN=1 throughout, reset released → io_resetOut=11 until edge 8; =10 after edge 8; =00 and io_ready=1 after edge 11; io_cause=0, io_faultCount=0.
- Lock flaps in WAIT_LOCK: lock drops for 1 cycle at edge 3 → lockcnt restarts; release timeline shifts later; io_faultCount stays 0; io_resetOut never changes before 4 consecutive lock_s highs.
- Lock loss in RUN: pllLock low for 1 cycle → 3 edges later io_resetOut=11, io_ready=0, io_cause=1, io_faultCount=1. After lock returns, full sequence repeats with the same spacing.
- Button debounce: buttonN low pulses of 2 cycles → no effect. Held low 8 cycles in RUN → fault, io_cause=2. Stays in HOLD until the button has been high ≥4 cycles, then re-sequences.
- Simultaneous fault mid-RELEASE: lock drop and debounced press on the same edge, with io_resetOut=10 → io_resetOut=11, io_cause=3. A forced 260 faults → io_faultCount saturates at 255.
- Synchronous reset asserted in RELEASE → all outputs return to reset values on that edge; the sequence restarts from HOLD afterwards.
